// File: rtl/video_pkg.sv
// Shared constants and FSM encoding for the video RAM and the video generator.
package video_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH = 11;
  localparam int unsigned VRAM_DATA_WIDTH = 8;
  localparam int unsigned VRAM_CNT_WIDTH  = 8;

  // CPU-port transaction state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2,
    ACK  = 2'd3
  } vram_state_e;

endpackage : video_pkg

// File: rtl/video_ram_arbiter_if.sv
// Bus bundle between the video RAM arbiter and its two masters.
//   video fetch : vid_req/vid_addr -> vid_data/vid_valid
//   CPU port    : cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ack
//   status      : collisions (saturating count of CPU-denied cycles)
// master = video generator + CPU side, slave = arbiter.
interface video_ram_arbiter_if
  import video_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = VRAM_CNT_WIDTH
) ();

  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [DATA_WIDTH-1:0] vid_data;
  logic                  vid_valid;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ack;

  logic [CNT_WIDTH-1:0]  collisions;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_data, vid_valid, cpu_rdata, cpu_ack, collisions
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_data, vid_valid, cpu_rdata, cpu_ack, collisions
  );

endinterface : video_ram_arbiter_if

// File: rtl/vram_sp_2k8.sv
// Inferable single-port synchronous RAM, one access per cycle.
//   clk   : clock
//   we    : write enable (write data at addr)
//   addr  : access address
//   wdata : write data
//   rdata : registered read of addr (old contents on a write cycle)
// No reset: contents survive system reset.
module vram_sp_2k8
  import video_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = VRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule : vram_sp_2k8

// File: rtl/video_ram_arbiter.sv
// Video RAM owner: arbitrates the time-critical video fetch port (always
// wins) against the CPU req/ack port (stalled on collision).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of video_ram_arbiter_if
//     vid_req/vid_addr    -> vid_data/vid_valid, fixed 1-cycle latency
//     cpu_req/we/addr/wdata -> cpu_rdata/cpu_ack, four-phase handshake
//     collisions          : saturating count of cycles the CPU was denied
module video_ram_arbiter
  import video_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = VRAM_CNT_WIDTH
) (
  input logic                clk,
  input logic                reset,
  video_ram_arbiter_if.slave bus
);

  vram_state_e           state_q, state_d;
  logic                  hold_we_q, hold_we_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic                  vid_pend_q, vid_pend_d;
  logic                  vid_valid_q, vid_valid_d;
  logic [DATA_WIDTH-1:0] vid_data_q, vid_data_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic [CNT_WIDTH-1:0]  collisions_q, collisions_d;

  logic                  ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c;
  logic [DATA_WIDTH-1:0] ram_rdata;

  vram_sp_2k8 #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      vid_pend_q   <= 1'b0;
      vid_valid_q  <= 1'b0;
      vid_data_q   <= '0;
      cpu_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      collisions_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      vid_pend_q   <= vid_pend_d;
      vid_valid_q  <= vid_valid_d;
      vid_data_q   <= vid_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      collisions_q <= collisions_d;
    end
  end

  // Next-state, RAM port mux and output updates
  always_comb begin
    state_d      = state_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ack_d    = cpu_ack_q;
    collisions_d = collisions_q;
    vid_data_d   = vid_data_q;

    // Video: RAM read on the request edge, output registered one edge later
    vid_pend_d  = bus.vid_req;
    vid_valid_d = vid_pend_q;
    if (vid_pend_q) begin
      vid_data_d = ram_rdata;
    end

    // Video owns the RAM whenever it asks; otherwise the holding registers drive it
    ram_we_c    = 1'b0;
    ram_addr_c  = bus.vid_req ? bus.vid_addr : hold_addr_q;
    ram_wdata_c = hold_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          hold_we_d    = bus.cpu_we;
          hold_addr_d  = bus.cpu_addr;
          hold_wdata_d = bus.cpu_wdata;
          state_d      = PEND;
        end
      end
      PEND: begin
        if (bus.vid_req) begin
          if (collisions_q != {CNT_WIDTH{1'b1}}) begin
            collisions_d = collisions_q + CNT_WIDTH'(1);
          end
        end else begin
          ram_we_c = hold_we_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        // ram_rdata still reflects the CPU access of the previous edge
        if (!hold_we_q) begin
          cpu_rdata_d = ram_rdata;
        end
        cpu_ack_d = 1'b1;
        state_d   = ACK;
      end
      ACK: begin
        if (!bus.cpu_req) begin
          cpu_ack_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.vid_data   = vid_data_q;
  assign bus.vid_valid  = vid_valid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.collisions = collisions_q;

endmodule : video_ram_arbiter

// File: tb/tb_video_ram_arbiter.sv
// Self-checking bench for video_ram_arbiter: directed scenarios with literal
// expectations, then random traffic checked against a cycle-level reference.
module tb_video_ram_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  video_ram_arbiter_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

  video_ram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory image with a known bit (bit 8) so unwritten bytes are never compared.
  bit   [8:0]  mmem [2048];
  bit          m_vid_valid, m_vid_known, p_vid, p_known;
  bit   [7:0]  m_vid_data, p_data;
  bit          m_ack, m_rdata_known, txn_open, served;
  bit   [7:0]  m_rdata, m_coll;
  bit          t_we;
  bit   [10:0] t_addr;
  bit   [7:0]  t_wdata;
  bit   [8:0]  rd_val;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_vid_valid   <= 1'b0;
      m_vid_data    <= 8'h00;
      m_vid_known   <= 1'b1;
      p_vid         <= 1'b0;
      p_known       <= 1'b0;
      p_data        <= 8'h00;
      m_ack         <= 1'b0;
      m_rdata       <= 8'h00;
      m_rdata_known <= 1'b1;
      m_coll        <= 8'h00;
      txn_open      <= 1'b0;
      served        <= 1'b0;
    end else begin
      // Video reads the image at the request edge and shows it one edge later
      m_vid_valid <= p_vid;
      if (p_vid) begin
        m_vid_data  <= p_data;
        m_vid_known <= p_known;
      end
      p_vid <= bus.vid_req;
      if (bus.vid_req) {p_known, p_data} <= mmem[bus.vid_addr];

      // CPU: accept when free, serve on the first edge without video, ack next
      if (served) begin
        served <= 1'b0;
        m_ack  <= 1'b1;
        if (!t_we) {m_rdata_known, m_rdata} <= rd_val;
      end else if (m_ack) begin
        if (!bus.cpu_req) begin
          m_ack    <= 1'b0;
          txn_open <= 1'b0;
        end
      end else if (txn_open) begin
        if (bus.vid_req) begin
          if (m_coll != 8'hFF) m_coll <= m_coll + 8'd1;
        end else begin
          if (t_we) mmem[t_addr] <= {1'b1, t_wdata};
          else      rd_val       <= mmem[t_addr];
          served <= 1'b1;
        end
      end else if (bus.cpu_req) begin
        txn_open <= 1'b1;
        t_we     <= bus.cpu_we;
        t_addr   <= bus.cpu_addr;
        t_wdata  <= bus.cpu_wdata;
      end
    end
  end

  // Compare DUT outputs to the model every cycle, away from the active edge
  always @(negedge clk) begin
    chk("vid_valid", 32'(bus.vid_valid), 32'(m_vid_valid));
    if (m_vid_known) chk("vid_data", 32'(bus.vid_data), 32'(m_vid_data));
    chk("cpu_ack", 32'(bus.cpu_ack), 32'(m_ack));
    if (m_rdata_known) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_rdata));
    chk("collisions", 32'(bus.collisions), 32'(m_coll));
  end

  // ---------------- stimulus helpers (called at posedge + #1) ----------------
  task automatic cpu_txn(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                         input int hold, input int exp_lat, output logic [7:0] rdata);
    int lat;
    bit got;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      got = bus.cpu_ack;
    end
    if (!got) chk("cpu_ack_timeout", 32'(0), 32'(1));
    else if (exp_lat != 0) chk("cpu_ack_latency", 32'(lat), 32'(exp_lat));
    rdata = bus.cpu_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("cpu_ack_hold", 32'(bus.cpu_ack), 32'(1));
    end
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic vid_fetch(input logic [10:0] addr, input logic [7:0] exp);
    bus.vid_req  = 1'b1;
    bus.vid_addr = addr;
    @(posedge clk); #1;
    bus.vid_req = 1'b0;
    @(posedge clk); #1;
    chk("vid_fetch_valid", 32'(bus.vid_valid), 32'(1));
    chk("vid_fetch_data", 32'(bus.vid_data), 32'(exp));
  endtask

  logic [7:0]  rd, rd2;
  logic [10:0] pool [16];
  bit          done;

  initial begin
    reset         = 1'b1;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    done          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vid_valid", 32'(bus.vid_valid), 32'(0));
    chk("reset_vid_data", 32'(bus.vid_data), 32'(0));
    chk("reset_cpu_ack", 32'(bus.cpu_ack), 32'(0));
    chk("reset_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
    chk("reset_collisions", 32'(bus.collisions), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Preload via the CPU port (no collisions possible)
    cpu_txn(1'b1, 11'h000, 8'h10, 0, 3, rd);
    cpu_txn(1'b1, 11'h028, 8'h38, 0, 3, rd);
    cpu_txn(1'b1, 11'h050, 8'h6C, 0, 3, rd);
    cpu_txn(1'b1, 11'h100, 8'hC6, 0, 3, rd);

    // Video read only, second request two cycles after the first
    vid_fetch(11'h000, 8'h10);
    vid_fetch(11'h028, 8'h38);

    // CPU write then read, no collision
    cpu_txn(1'b1, 11'h7A0, 8'h62, 0, 3, rd);
    cpu_txn(1'b0, 11'h7A0, 8'h00, 0, 3, rd);
    chk("rd_7a0", 32'(rd), 32'(8'h62));
    chk("no_collisions", 32'(bus.collisions), 32'(0));

    // Collision: video hits the pending write's address and sees old data
    fork
      cpu_txn(1'b1, 11'h050, 8'hAA, 0, 4, rd);
      begin
        @(posedge clk); #1;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 11'h050;
        @(posedge clk); #1;
        bus.vid_req = 1'b0;
        @(posedge clk); #1;
        chk("coll_vid_valid", 32'(bus.vid_valid), 32'(1));
        chk("coll_vid_old", 32'(bus.vid_data), 32'(8'h6C));
      end
    join
    chk("coll_count", 32'(bus.collisions), 32'(1));
    vid_fetch(11'h050, 8'hAA);

    // Starvation and saturation
    fork
      begin
        cpu_txn(1'b0, 11'h7A0, 8'h00, 0, 0, rd2);
        chk("starve_rdata", 32'(rd2), 32'(8'h62));
      end
      begin
        bus.vid_req  = 1'b1;
        bus.vid_addr = 11'h028;
        repeat (300) @(posedge clk);
        #1;
        chk("starve_ack_low", 32'(bus.cpu_ack), 32'(0));
        chk("starve_sat", 32'(bus.collisions), 32'(8'hFF));
        bus.vid_req = 1'b0;
        @(posedge clk); #1;
        chk("starve_ack_1", 32'(bus.cpu_ack), 32'(0));
        @(posedge clk); #1;
        chk("starve_ack_2", 32'(bus.cpu_ack), 32'(1));
      end
    join

    // Handshake hold: ack stays high, single access only
    cpu_txn(1'b1, 11'h200, 8'h5A, 5, 3, rd);
    cpu_txn(1'b0, 11'h200, 8'h00, 5, 3, rd);
    chk("hold_rdata", 32'(rd), 32'(8'h5A));
    vid_fetch(11'h200, 8'h5A);

    // Reset while a write of 0xFF to 0x100 is pending
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 11'h100;
    bus.cpu_wdata = 8'hFF;
    bus.vid_req   = 1'b1;
    bus.vid_addr  = 11'h000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_vid_valid", 32'(bus.vid_valid), 32'(0));
    chk("rst_vid_data", 32'(bus.vid_data), 32'(0));
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'(0));
    chk("rst_collisions", 32'(bus.collisions), 32'(0));
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    cpu_txn(1'b0, 11'h100, 8'h00, 0, 3, rd);
    chk("rst_write_dropped", 32'(rd), 32'(8'hC6));

    // Random traffic over a preloaded address pool
    for (int i = 0; i < 16; i++) begin
      pool[i] = 11'($urandom_range(0, 2047));
      cpu_txn(1'b1, pool[i], 8'($urandom), 0, 3, rd);
    end
    fork
      begin
        for (int t = 0; t < 150; t++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          cpu_txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], 8'($urandom),
                  $urandom_range(0, 3), 0, rd);
        end
        done = 1'b1;
      end
      begin
        int gap;
        gap = 2;
        while (!done) begin
          if (bus.vid_req) begin
            bus.vid_req = 1'b0;
            gap = 1;
          end else if (gap >= 2 && $urandom_range(0, 2) == 0) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = pool[$urandom_range(0, 15)];
          end else begin
            gap++;
          end
          @(posedge clk); #1;
        end
        bus.vid_req = 1'b0;
      end
    join

    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_video_ram_arbiter

// File: doc/video_ram_arbiter.md
Name: video_ram_arbiter

Overview:
Owns the 2048x8 video RAM that the composite video generator reads pixel bytes from. It arbitrates two masters: the video fetch port, which is time-critical and always wins, and the Z8 CPU bus port, which uses a four-phase req/ack handshake and is stalled on collision. It sits directly upstream of the video generator and replaces that generator's private memory array.

Parameters:
ADDR_WIDTH, 11, address width of both ports; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 8, byte width of the RAM and of both data buses.
CNT_WIDTH, 8, width of the saturating collision counter.

Ports:
clk  in  1  system clock (8 MHz pixel clock)
reset  in  1  asynchronous, active-high reset
vid_req  in  1  video fetch request, single-cycle pulse
vid_addr  in  ADDR_WIDTH  video fetch address, sampled when vid_req=1
vid_data  out  DATA_WIDTH  fetched byte
vid_valid  out  1  one-cycle pulse; vid_data is valid in that cycle
cpu_req  in  1  CPU request; held high until cpu_ack is seen
cpu_we  in  1  1=write, 0=read; stable while cpu_req=1
cpu_addr  in  ADDR_WIDTH  CPU address; stable while cpu_req=1
cpu_wdata  in  DATA_WIDTH  CPU write data; stable while cpu_req=1
cpu_rdata  out  DATA_WIDTH  read data; valid while cpu_ack=1
cpu_ack  out  1  transaction complete; stays high until cpu_req falls
collisions  out  CNT_WIDTH  count of cycles in which the CPU was denied; saturates

Behaviour:
- RAM: single port with synchronous read. Exactly one access per cycle. Contents are not cleared by reset.
- Reset values: vid_data=0, vid_valid=0, cpu_rdata=0, cpu_ack=0, collisions=0, FSM=IDLE, holding registers=0.
- Video path: vid_req=1 at edge N accesses vid_addr. vid_data and vid_valid=1 appear after edge N+1 (fixed latency of 1). vid_valid is low otherwise. vid_data holds its last value between fetches. A video access is never delayed or dropped.
- Video spacing: the generator guarantees at least 2 cycles between vid_req pulses (nominally one every 8). If vid_req stays high continuously, the CPU may starve. That is legal, not an error.
- CPU FSM:
  - IDLE: when cpu_req=1, latch we/addr/wdata into holding registers and go to PEND. No RAM access happens in the latch cycle.
  - PEND: if vid_req=0, perform the access from the holding registers and go to DONE. If vid_req=1, stay in PEND and increment collisions (saturating at all-ones).
  - DONE: on the cycle after the access, cpu_rdata is loaded (reads only; unchanged on writes), cpu_ack=1, go to ACK.
  - ACK: hold cpu_ack=1 until cpu_req=0, then cpu_ack=0 and return to IDLE.
- Minimum CPU latency: cpu_req rises at edge N, cpu_ack is high after edge N+3. Each collision adds one cycle.
- Same-address ordering:
  - A CPU write performed at edge K is seen by a video read issued at edge K+1 or later.
  - A video read colliding with a pending CPU write to the same address returns the old data.
- A new cpu_req is not accepted until the FSM has returned to IDLE. Re-asserting cpu_req in the same cycle ack falls is legal and is latched on the next edge.
- Reset mid-transaction: the pending transaction is abandoned. A write not yet performed is never performed, and a write already performed is kept.
- Address width: addresses wrap modulo 2**ADDR_WIDTH. No out-of-range checking.

Decomposition:
- Shared package video_pkg holds VRAM_ADDR_WIDTH=11, VRAM_DATA_WIDTH=8, and the FSM state encoding (IDLE, PEND, DONE, ACK, 2 bits). The video generator uses the same constants.
- One sub-module, vram_sp_2k8: an inferable single-port synchronous RAM with inputs we, addr, wdata and output rdata, 1-cycle read. The arbitration logic stays in video_ram_arbiter.

Test Plan:
- Video read only: preload addr 0x000=0x10 and 0x028=0x38. Pulse vid_req at 0x000, then at 0x028 two cycles later -> vid_valid pulses 1 cycle after each request, with vid_data 0x10 then 0x38.
- CPU write, then read, no collision: write 0x7A0<-0x62, then read 0x7A0 -> each cpu_ack rises 3 cycles after cpu_req, cpu_rdata=0x62, collisions=0.
- Collision: CPU write 0x050<-0xAA enters PEND while vid_req pulses at 0x050 (old value 0x6C) -> vid_data=0x6C, CPU write completes 1 cycle later, collisions=1. The next video read of 0x050 returns 0xAA.
- Starvation and saturation: hold vid_req=1 for 300 cycles during a CPU read -> cpu_ack stays 0, collisions saturates at 0xFF. Drop vid_req -> cpu_ack arrives 2 cycles later.
- Handshake hold: keep cpu_req high 5 cycles after ack -> cpu_ack stays 1 throughout. No second access occurs and the RAM is unchanged.
- Reset mid-operation: assert reset while in PEND with a write of 0xFF to 0x100 (old 0xC6) -> all outputs 0 immediately. A later read of 0x100 returns 0xC6.
